// File: rtl/conv_layer_if.sv
// Memory-port and start/busy/done bundle of the convolution layer engine.
// master = engine side, slave = layer controller / memory side.
interface conv_layer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wt_addr;
    logic [DATA_W-1:0] wt_data;
    logic [ADDR_W-1:0] img_addr;
    logic [DATA_W-1:0] img_data;
    logic [ADDR_W-1:0] bias_addr;
    logic [DATA_W-1:0] bias_data;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_we;

    modport master (
        input  start, wt_data, img_data, bias_data,
        output busy, done, wt_addr, img_addr, bias_addr, out_addr, out_data, out_we
    );

    modport slave (
        output start, wt_data, img_data, bias_data,
        input  busy, done, wt_addr, img_addr, bias_addr, out_addr, out_data, out_we
    );
endinterface

// File: rtl/conv_layer_engine.sv
// Self-sequencing 2-D convolution layer: one time-multiplexed MAC, bias, requantise, saturate.
// Optional macro CONV_RELU_EN fuses a ReLU after saturation (same latency).
module conv_layer_engine #(
    parameter int IMG_DIM    = 32,
    parameter int IN_CH      = 3,
    parameter int OUT_CH     = 32,
    parameter int KERNEL     = 5,
    parameter int PADDING    = 2,
    parameter int STRIDE     = 1,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int ADDR_W     = 16,
    parameter int BIAS_SHIFT = 6,
    parameter int OUT_SHIFT  = 9
) (
    input  logic          clk,
    input  logic          reset,
    conv_layer_if.master  bus
);

    localparam int OUT_DIM = (IMG_DIM + 2*PADDING - KERNEL)/STRIDE + 1;
    localparam int N       = KERNEL*KERNEL*IN_CH;
    localparam int YW      = $clog2(OUT_DIM + 1);
    localparam int OW      = $clog2(OUT_CH + 1);
    localparam int KW      = $clog2(KERNEL + 1);
    localparam int CW      = $clog2(IN_CH + 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));

    if (ACC_W < 2*DATA_W + 1 + $clog2(N + 1)) begin : g_acc_w_too_small
        $error("conv_layer_engine: ACC_W too narrow for the worst-case MAC sum");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MAC, S_LAST, S_WRITE, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [YW-1:0] y_q, y_d, x_q, x_d;
    logic [OW-1:0] o_q, o_d;
    logic [KW-1:0] ky_q, ky_d, kx_q, kx_d;
    logic [CW-1:0] c_q, c_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
    logic [ADDR_W-1:0] wt_addr_q, wt_addr_d, img_addr_q, img_addr_d;
    logic [ADDR_W-1:0] bias_addr_q, bias_addr_d, out_addr_q, out_addr_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic out_we_q, out_we_d, busy_q, busy_d, done_q, done_d;

    int   row_d, col_d;
    logic tap_in_d;
    logic first_tap;

    logic signed [DATA_W-1:0]   wt_s;
    logic signed [DATA_W:0]     px_s;
    logic signed [2*DATA_W:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext, bias_ext;

    // Pixels are unsigned, so they get a zero sign bit before the signed multiply.
    assign wt_s     = signed'(bus.wt_data);
    assign px_s     = signed'({1'b0, bus.img_data});
    assign prod     = wt_s * px_s;
    assign prod_ext = ACC_W'(prod);
    assign bias_ext = ACC_W'(signed'(bus.bias_data)) <<< BIAS_SHIFT;

    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0]  s;
        logic signed [DATA_W-1:0] r;
        s = a >>> OUT_SHIFT;
        if (s > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
        else if (s < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
        else                  r = s[DATA_W-1:0];
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] activate(input logic signed [DATA_W-1:0] v);
`ifdef CONV_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        state_d = state_q;
        y_d  = y_q;
        x_d  = x_q;
        o_d  = o_q;
        ky_d = ky_q;
        kx_d = kx_q;
        c_d  = c_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_BIAS;
            S_BIAS:  state_d = S_MAC;
            S_MAC: begin
                if (c_q == CW'(IN_CH - 1)) begin
                    c_d = '0;
                    if (kx_q == KW'(KERNEL - 1)) begin
                        kx_d = '0;
                        if (ky_q == KW'(KERNEL - 1)) begin
                            ky_d    = '0;
                            state_d = S_LAST;
                        end else begin
                            ky_d = ky_q + KW'(1);
                        end
                    end else begin
                        kx_d = kx_q + KW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            S_LAST:  state_d = S_WRITE;
            S_WRITE: begin
                state_d = S_BIAS;
                if (o_q == OW'(OUT_CH - 1)) begin
                    o_d = '0;
                    if (x_q == YW'(OUT_DIM - 1)) begin
                        x_d = '0;
                        if (y_q == YW'(OUT_DIM - 1)) begin
                            y_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + YW'(1);
                    end
                end else begin
                    o_d = o_q + OW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Addresses are registered, so they are derived from the next-cycle counters.
        row_d    = int'(y_d)*STRIDE + int'(ky_d) - PADDING;
        col_d    = int'(x_d)*STRIDE + int'(kx_d) - PADDING;
        tap_in_d = (row_d >= 0) && (row_d < IMG_DIM) && (col_d >= 0) && (col_d < IMG_DIM);

        vld_p0_d = (state_d == S_MAC) && tap_in_d;
        vld_p1_d = vld_p0_q;

        wt_addr_d = wt_addr_q;
        if (state_d == S_MAC)
            wt_addr_d = ADDR_W'(((int'(o_d)*KERNEL + int'(ky_d))*KERNEL + int'(kx_d))*IN_CH + int'(c_d));
        img_addr_d = img_addr_q;
        if ((state_d == S_MAC) && tap_in_d)
            img_addr_d = ADDR_W'((row_d*IMG_DIM + col_d)*IN_CH + int'(c_d));
        bias_addr_d = (state_d == S_BIAS) ? ADDR_W'(o_d) : bias_addr_q;

        // Tap data lags its address by one cycle; vld_p1 marks whether it lies inside the image.
        first_tap = (ky_q == '0) && (kx_q == '0) && (c_q == '0);
        acc_d     = acc_q;
        if ((state_q == S_MAC) && first_tap)
            acc_d = bias_ext;
        else if (((state_q == S_MAC) || (state_q == S_LAST)) && vld_p1_q)
            acc_d = acc_q + prod_ext;

        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        if (state_d == S_WRITE) begin
            out_addr_d = ADDR_W'((int'(y_q)*OUT_DIM + int'(x_q))*OUT_CH + int'(o_q));
            out_data_d = activate(sat_shift(acc_d));
        end
        out_we_d = (state_d == S_WRITE);
        busy_d   = (state_d inside {S_BIAS, S_MAC, S_LAST, S_WRITE});
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            y_q         <= '0;
            x_q         <= '0;
            o_q         <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            wt_addr_q   <= '0;
            img_addr_q  <= '0;
            bias_addr_q <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            x_q         <= x_d;
            o_q         <= o_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            vld_p0_q    <= vld_p0_d;
            vld_p1_q    <= vld_p1_d;
            wt_addr_q   <= wt_addr_d;
            img_addr_q  <= img_addr_d;
            bias_addr_q <= bias_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_we_q    <= out_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wt_addr   = wt_addr_q;
    assign bus.img_addr  = img_addr_q;
    assign bus.bias_addr = bias_addr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_we    = out_we_q;

endmodule
